tm1638_key_events: RTL
======================

// Module: tm1638_key_events
// PURPOSE
//  Consumes the raw 8-bit key vector returned by tm1638_board_controller (keys).
//  Debounces each key independently and exports a stable key_state vector.
//  Turns every debounced edge into a press/release event in a small FIFO with a valid/ready output.
//  Application logic reads button input event-by-event instead of polling tm_key.
// PARAMETERS
//  W_KEY            8       number of keys; sets the width of keys and key_state
//  DEBOUNCE_CYCLES  270000  consecutive stable cycles needed to accept a change (10 ms @ 27 MHz); >= 2
//  FIFO_DEPTH       4       event FIFO entries; power of two, >= 2
// PORTS
//  clk        in   1                   system clock (same domain as board controller)
//  rst        in   1                   reset, asynchronous, active-high
//  keys       in   W_KEY               raw key bits from tm1638_board_controller
//  key_state  out  W_KEY               debounced key levels
//  evt_valid  out  1                   FIFO head holds an event
//  evt_ready  in   1                   consumer accepts head this cycle
//  evt_press  out  1                   head event type: 1 = press, 0 = release
//  evt_key    out  $clog2(W_KEY)       head event key index
//  overflow   out  1                   sticky: at least one event was lost
//  ovf_clear  in   1                   synchronous clear of overflow
// BEHAVIOUR
//  Reset: all outputs, keys_q, counters, pending bits and FIFO pointers/count go to 0.
//  - keys is registered once into keys_q.
//  Debounce, per key i, with counter cnt[i] of width $clog2(DEBOUNCE_CYCLES):
//  - keys_q[i]==key_state[i]: cnt[i] <= 0.
//  - Otherwise, if cnt[i]==DEBOUNCE_CYCLES-1: key_state[i] <= keys_q[i], cnt[i] <= 0, raise an edge.
//  - Otherwise: cnt[i] <= cnt[i]+1.
//  - A glitch shorter than DEBOUNCE_CYCLES restarts the count; key_state does not change.
//  - Latency: a held keys change appears on key_state DEBOUNCE_CYCLES+1 clocks after the first edge sampling it.
//  Pending stage, per key: pend[i] and pend_type[i].
//  - On an edge, pend[i] <= 1 and pend_type[i] <= new level.
//  - Edge while pend[i] already set (opposite type): pend[i] <= 0 (pair cancelled), overflow <= 1.
//  Arbiter:
//  - Each cycle with the FIFO not full (registered count < FIFO_DEPTH), pushes the lowest-index pending key.
//  - Pushed entry is {pend_type, index}; that pend bit clears in the same cycle.
//  - At most 1 push per cycle. With simultaneous edges, lower indices go first on consecutive cycles.
//  - An edge arriving in the same cycle that its pend bit is pushed sets pend again (no loss).
//  FIFO is first-word-fall-through:
//  - evt_valid = (count != 0); evt_press/evt_key show the head entry, 0 when empty.
//  - Pop happens on evt_valid && evt_ready. evt_ready while empty is ignored.
//  - Push and pop in the same cycle: count is unchanged and pointers wrap modulo FIFO_DEPTH.
//  - Full FIFO: no push. Pending bits wait and no event is dropped until a cancel occurs.
//  - Event latency: evt_valid rises 2 clocks after the key_state change (FIFO empty, no other pending).
//  overflow:
//  - Set by a cancel; stays set until ovf_clear.
//  - ovf_clear and a new cancel in the same cycle: set wins.
//  - Async rst mid-operation clears counters, pending bits, FIFO and overflow at once; no event is emitted for the reset.
// TESTING (bench uses DEBOUNCE_CYCLES=4, FIFO_DEPTH=4, W_KEY=8)
//  1. keys=8'h01 held -> key_state=8'h01 5 clks later; evt_valid 2 clks after that; head press=1,key=0; ready pops it and evt_valid drops.
//  2. keys[3] toggled every 2 clks for 40 clks, then 0 -> key_state stays 8'h00, no event, overflow=0.
//  3. keys 8'h00->8'hA0 in one cycle -> events (press,5) then (press,7) on consecutive cycles.
//  4. evt_ready=0; press/release keys 0..2 (6 edges) -> FIFO holds 4 entries in key/time order; next 2 come out after popping; overflow=0.
//  5. FIFO full and key 4 pending press, then key 4 released and debounced -> pend cancelled, overflow=1; ovf_clear -> overflow=0.
//  6. rst asserted mid-debounce with 2 FIFO entries -> all outputs 0 immediately; after release, a stable keys=8'h01 gives a fresh press after 5 clks.

Source files
------------

// File: rtl/tm1638_key_events.sv
// Debounces the TM1638 raw key vector and turns every accepted level change
// into a press/release event held in a small first-word-fall-through FIFO.
module tm1638_key_events #(
  parameter int W_KEY           = 8,
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [W_KEY-1:0]         keys,
  output logic [W_KEY-1:0]         key_state,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic                     evt_press,
  output logic [$clog2(W_KEY)-1:0] evt_key,
  output logic                     overflow,
  input  logic                     ovf_clear
);

  localparam int KW    = $clog2(W_KEY);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int EW    = KW + 1;

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PW:0]      FIFO_FULL = (PW + 1)'(FIFO_DEPTH);
  localparam logic [PW:0]      COUNT_ONE = (PW + 1)'(1);
  localparam logic [PW-1:0]    PTR_ONE   = PW'(1);
  localparam logic [W_KEY-1:0] KEY_ONE   = W_KEY'(1);

  logic [W_KEY-1:0] keys_q_reg;
  logic [W_KEY-1:0] key_state_w;
  logic [W_KEY-1:0] key_edge_w;
  logic [W_KEY-1:0] pend_w;
  logic [W_KEY-1:0] pend_type_w;
  logic [W_KEY-1:0] cancel_w;
  logic [W_KEY-1:0] grant;

  logic             push_en;
  logic             pop_en;
  logic [KW-1:0]    push_idx;
  logic             push_type;

  logic [EW-1:0]    mem [FIFO_DEPTH];
  logic [EW-1:0]    head;
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW:0]      count_reg;
  logic             overflow_reg;

  // Single input register; the board controller already runs on clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keys_q_reg <= '0;
    end else begin
      keys_q_reg <= keys;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < W_KEY; gi++) begin : g_key
      logic [CNT_W-1:0] cnt_reg;
      logic             state_reg;
      logic             edge_reg;
      logic             pend_reg;
      logic             pend_type_reg;
      logic             pushed_w;

      assign key_state_w[gi] = state_reg;
      assign key_edge_w[gi]  = edge_reg;
      assign pend_w[gi]      = pend_reg;
      assign pend_type_w[gi] = pend_type_reg;
      assign pushed_w        = push_en && grant[gi];

      // A second edge before the first one reached the FIFO annihilates the pair.
      assign cancel_w[gi] = edge_reg && pend_reg && !pushed_w;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg   <= '0;
          state_reg <= 1'b0;
          edge_reg  <= 1'b0;
        end else begin
          edge_reg <= 1'b0;
          if (keys_q_reg[gi] == state_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_MAX) begin
            state_reg <= keys_q_reg[gi];
            cnt_reg   <= '0;
            edge_reg  <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
      end

      // key_state already holds the new level when edge_reg is high.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pend_reg      <= 1'b0;
          pend_type_reg <= 1'b0;
        end else if (edge_reg) begin
          if (pend_reg && !pushed_w) begin
            pend_reg <= 1'b0;
          end else begin
            pend_reg      <= 1'b1;
            pend_type_reg <= state_reg;
          end
        end else if (pushed_w) begin
          pend_reg <= 1'b0;
        end
      end
    end
  endgenerate

  assign key_state = key_state_w;

  // Fixed priority: the lowest pending index wins the single push slot.
  always_comb begin
    grant    = pend_w & (~pend_w + KEY_ONE);
    push_idx = '0;
    for (int i = W_KEY - 1; i >= 0; i--) begin
      if (pend_w[i]) begin
        push_idx = KW'(i);
      end
    end
    push_type = |(grant & pend_type_w);
  end

  assign push_en = (|pend_w) && (count_reg != FIFO_FULL);
  assign pop_en  = evt_valid && evt_ready;

  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr_reg] <= {push_type, push_idx};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_en) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop_en) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      case ({push_en, pop_en})
        2'b10:   count_reg <= count_reg + COUNT_ONE;
        2'b01:   count_reg <= count_reg - COUNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Head is shown directly from storage; outputs are forced low while empty.
  assign head      = mem[rd_ptr_reg];
  assign evt_valid = (count_reg != '0);
  assign evt_press = evt_valid ? head[KW] : 1'b0;
  assign evt_key   = evt_valid ? head[KW-1:0] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_reg <= 1'b0;
    end else if (|cancel_w) begin
      overflow_reg <= 1'b1;
    end else if (ovf_clear) begin
      overflow_reg <= 1'b0;
    end
  end

  assign overflow = overflow_reg;

endmodule
